wb_bus_master: RTL and testbench
================================

WB_BUS_MASTER -- requirements
Module: wb_bus_master

Interface
REQ-001 Parameter WORD, default 16: data/address width in bits.
REQ-002 Parameter TIMEOUT, default 15: max cycles a bus cycle waits for ack_i; legal range 1..255.
REQ-003 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-004 nrst_i  in  1  reset; asynchronous, active-low.
REQ-005 cpuReq_i  in  1  CPU transfer request, level; sampled only in IDLE.
REQ-006 cpuWe_i  in  1  1 = write, 0 = read; sampled with cpuReq_i.
REQ-007 cpuAdr_i  in  WORD  transfer address; sampled with cpuReq_i.
REQ-008 cpuDat_i  in  WORD  write data; sampled with cpuReq_i.
REQ-009 cpuDat_o  out  WORD  read data / error pattern; registered.
REQ-010 cpuDone_o  out  1  one-cycle pulse: transfer finished (ok or error).
REQ-011 cpuErr_o  out  1  one-cycle pulse coincident with cpuDone_o on timeout.
REQ-012 busy_o  out  1  high while in BUS state.
REQ-013 stb_o, cyc_o  out  1 each  Wishbone strobe/cycle to the slave arbiter.
REQ-014 we_o  out  1  Wishbone write enable.
REQ-015 adr_o  out  WORD  Wishbone address, upper bits select the slave.
REQ-016 dat_o  out  WORD  Wishbone write data.
REQ-017 ack_i  in  1  Wishbone acknowledge from the slave arbiter.
REQ-018 dat_i  in  WORD  Wishbone read data from the slave arbiter.

Function
REQ-019 Two-state FSM, IDLE and BUS; all outputs driven from registers, no combinational input-to-output path.
REQ-020 IDLE, edge with cpuReq_i=1: latch cpuWe_i/cpuAdr_i/cpuDat_i into we_o/adr_o/dat_o, set stb_o=cyc_o=1, clear timeout counter, enter BUS.
REQ-021 IDLE, edge with cpuReq_i=0: remain IDLE; stb_o=cyc_o=0; ack_i and dat_i ignored.
REQ-022 BUS: stb_o, cyc_o, we_o, adr_o, dat_o held constant; cpuReq_i and CPU inputs ignored.
REQ-023 BUS, edge with ack_i=1: stb_o=cyc_o=0, cpuDone_o=1 for the next cycle, enter IDLE; read: cpuDat_o<=dat_i; write: cpuDat_o unchanged.
REQ-024 BUS, edge with ack_i=0: counter increments; if counter was TIMEOUT-1, abort: stb_o=cyc_o=0, cpuDone_o=cpuErr_o=1 next cycle, read: cpuDat_o<=all ones, write: cpuDat_o unchanged, enter IDLE.
REQ-025 Consequence: stb_o high for at most TIMEOUT cycles; ack_i on the final counted edge completes normally (ack wins over timeout).
REQ-026 Latency: request sampled at edge N, stb_o high from N; ack_i high at edge N+1 gives cpuDone_o high in cycle after N+1 (2 edges minimum).
REQ-027 cyc_o low for at least one cycle between consecutive transfers; request may be accepted in the same cycle cpuDone_o is high.
REQ-028 cpuDone_o/cpuErr_o never high more than one consecutive cycle; cpuErr_o never high without cpuDone_o.
REQ-029 we_o, adr_o, dat_o retain last transfer's values in IDLE.
REQ-030 Counter width ceil(log2(TIMEOUT+1)); no wrap possible.

Reset
REQ-031 nrst_i=0 asynchronously forces IDLE; stb_o, cyc_o, we_o, busy_o, cpuDone_o, cpuErr_o=0; adr_o, dat_o, cpuDat_o=0; counter=0.
REQ-032 Reset mid-BUS drops stb_o/cyc_o immediately, no done/err pulse; first request is accepted on the first edge after nrst_i rises.

Verification
REQ-033 Read, adr 0x4010, ack_i high 3 cycles after stb_o, dat_i=0xBEEF -> adr_o=0x4010, we_o=0, cpuDat_o=0xBEEF, one cpuDone_o pulse, cpuErr_o=0.
REQ-034 Write, adr 0xC002, data 0x1234, ack in first stb_o cycle -> we_o=1, dat_o=0x1234, cpuDone_o 2 edges after request, cpuDat_o unchanged.
REQ-035 Read to silent slave, TIMEOUT=15 -> stb_o high exactly 15 cycles, cpuDone_o=cpuErr_o=1 one cycle, cpuDat_o=0xFFFF.
REQ-036 ack_i on 15th stb_o cycle (TIMEOUT=15) -> normal completion, cpuErr_o=0.
REQ-037 cpuReq_i held high for 3 transfers, ack immediate -> cyc_o low one cycle between each, 3 done pulses, change of cpuAdr_i during BUS ignored.
REQ-038 nrst_i low during BUS cycle 2 -> stb_o/cyc_o 0 immediately, no cpuDone_o; new request after release completes normally.

Source files
------------

// File: rtl/wb_bus_master_if.sv
// wb_bus_master_if
// Wishbone bus bundle between the bus master and the slave arbiter.
//   stb_o, cyc_o : strobe / cycle, driven by the master
//   we_o         : write enable, driven by the master
//   adr_o, dat_o : address and write data, driven by the master
//   ack_i        : acknowledge, driven by the slave side
//   dat_i        : read data, driven by the slave side
interface wb_bus_master_if #(
  parameter int WORD = 16
) ();
  logic            stb_o;
  logic            cyc_o;
  logic            we_o;
  logic [WORD-1:0] adr_o;
  logic [WORD-1:0] dat_o;
  logic            ack_i;
  logic [WORD-1:0] dat_i;

  modport master (
    output stb_o, cyc_o, we_o, adr_o, dat_o,
    input  ack_i, dat_i
  );

  modport slave (
    input  stb_o, cyc_o, we_o, adr_o, dat_o,
    output ack_i, dat_i
  );
endinterface

// File: rtl/wb_bus_master.sv
// wb_bus_master
// Turns a level CPU request into one Wishbone single-beat cycle, with a
// timeout that aborts the cycle when the slave never acknowledges.
//   clk_i     : sole clock
//   nrst_i    : asynchronous active-low reset
//   cpuReq_i  : transfer request, sampled only in IDLE
//   cpuWe_i   : 1 = write, 0 = read
//   cpuAdr_i  : transfer address
//   cpuDat_i  : write data
//   cpuDat_o  : read data, all ones after a read timeout
//   cpuDone_o : one-cycle pulse when a transfer finishes
//   cpuErr_o  : one-cycle pulse alongside cpuDone_o on timeout
//   busy_o    : high while a bus cycle is in flight
//   wb        : Wishbone master side
//
// state | meaning
// IDLE  | no bus cycle; waiting for cpuReq_i
// BUS   | stb/cyc asserted; waiting for ack_i or timeout
module wb_bus_master #(
  parameter int WORD    = 16,
  parameter int TIMEOUT = 15
) (
  input  logic            clk_i,
  input  logic            nrst_i,
  input  logic            cpuReq_i,
  input  logic            cpuWe_i,
  input  logic [WORD-1:0] cpuAdr_i,
  input  logic [WORD-1:0] cpuDat_i,
  output logic [WORD-1:0] cpuDat_o,
  output logic            cpuDone_o,
  output logic            cpuErr_o,
  output logic            busy_o,
  wb_bus_master_if.master wb
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUS} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      wb.stb_o  <= 1'b0;
      wb.cyc_o  <= 1'b0;
      wb.we_o   <= 1'b0;
      wb.adr_o  <= '0;
      wb.dat_o  <= '0;
      cpuDat_o  <= '0;
      cpuDone_o <= 1'b0;
      cpuErr_o  <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      // done/err are single-cycle pulses unless set below
      cpuDone_o <= 1'b0;
      cpuErr_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpuReq_i) begin
            wb.we_o  <= cpuWe_i;
            wb.adr_o <= cpuAdr_i;
            wb.dat_o <= cpuDat_i;
            wb.stb_o <= 1'b1;
            wb.cyc_o <= 1'b1;
            busy_o   <= 1'b1;
            cnt      <= '0;
            state    <= BUS;
          end
        end
        BUS: begin
          // ack is checked first so an ack on the last counted edge completes normally
          if (wb.ack_i) begin
            wb.stb_o  <= 1'b0;
            wb.cyc_o  <= 1'b0;
            busy_o    <= 1'b0;
            cpuDone_o <= 1'b1;
            if (!wb.we_o) cpuDat_o <= wb.dat_i;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              wb.stb_o  <= 1'b0;
              wb.cyc_o  <= 1'b0;
              busy_o    <= 1'b0;
              cpuDone_o <= 1'b1;
              cpuErr_o  <= 1'b1;
              if (!wb.we_o) cpuDat_o <= '1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_master.sv
// tb_wb_bus_master
// Directed bench for wb_bus_master (WORD=16, TIMEOUT=15). The bench acts as
// both the CPU and the Wishbone slave; inputs change and outputs are sampled
// on the falling clock edge.
module tb_wb_bus_master;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req;
  logic        we;
  logic [15:0] adr;
  logic [15:0] wdat;
  logic [15:0] cpu_dat;
  logic        done;
  logic        err;
  logic        busy;

  always #5 clk = ~clk;

  wb_bus_master_if #(.WORD(16)) wb ();

  wb_bus_master #(.WORD(16), .TIMEOUT(15)) dut (
    .clk_i     (clk),
    .nrst_i    (nrst),
    .cpuReq_i  (req),
    .cpuWe_i   (we),
    .cpuAdr_i  (adr),
    .cpuDat_i  (wdat),
    .cpuDat_o  (cpu_dat),
    .cpuDone_o (done),
    .cpuErr_o  (err),
    .busy_o    (busy),
    .wb        (wb.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request (caller sits at a falling edge). ack_at = d raises ack_i
  // for the d-th edge after acceptance; 0 means the slave never answers.
  // done_k is the sample index (edges after acceptance) of the first done pulse.
  task automatic run_xfer(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] rd, input int ack_at,
                          output int stb_n, output int done_n, output int err_n,
                          output int done_k);
    stb_n = 0; done_n = 0; err_n = 0; done_k = -1;
    req = 1'b1; we = w; adr = a; wdat = d;
    wb.dat_i = rd; wb.ack_i = (ack_at == 0) ? 1'b0 : 1'b0;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) req = 1'b0;
      if (wb.stb_o) stb_n++;
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (err) err_n++;
      wb.ack_i = (ack_at != 0) && (ack_at == k + 1);
    end
    wb.ack_i = 1'b0;
  endtask

  int          stb_n, done_n, err_n, done_k;
  logic [5:0]  cyc_pat, done_pat;
  logic [15:0] adr1, adr2;
  int          extra_done, rst_done;

  initial begin
    nrst = 1'b0; req = 1'b0; we = 1'b0; adr = '0; wdat = '0;
    wb.ack_i = 1'b0; wb.dat_i = '0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_ctl", {28'd0, wb.stb_o, wb.cyc_o, wb.we_o, busy}, 32'h0);
    check("rst_pulse", {30'd0, done, err}, 32'h0);
    check("rst_adr_dat", {wb.adr_o, wb.dat_o}, 32'h0);
    check("rst_cpu_dat", {16'd0, cpu_dat}, 32'h0);
    nrst = 1'b1;

    // read, ack three cycles after stb rises
    run_xfer(1'b0, 16'h4010, 16'h0, 16'hBEEF, 3, stb_n, done_n, err_n, done_k);
    check("rd_adr", {16'd0, wb.adr_o}, 32'h4010);
    check("rd_we", {31'd0, wb.we_o}, 32'h0);
    check("rd_data", {16'd0, cpu_dat}, 32'hBEEF);
    check("rd_stb_cycles", stb_n, 3);
    check("rd_done_cnt", done_n, 1);
    check("rd_done_at", done_k, 3);
    check("rd_err", err_n, 0);

    // write, ack in the first stb cycle
    run_xfer(1'b1, 16'hC002, 16'h1234, 16'h5555, 1, stb_n, done_n, err_n, done_k);
    check("wr_we_adr", {15'd0, wb.we_o, wb.adr_o}, {15'd0, 1'b1, 16'hC002});
    check("wr_dat_o", {16'd0, wb.dat_o}, 32'h1234);
    check("wr_done_at", done_k, 1);
    check("wr_done_cnt", done_n, 1);
    check("wr_cpu_dat_kept", {16'd0, cpu_dat}, 32'hBEEF);
    check("wr_idle_ctl", {30'd0, wb.stb_o, wb.cyc_o}, 32'h0);

    // read to a silent slave
    run_xfer(1'b0, 16'h8000, 16'h0, 16'h1111, 0, stb_n, done_n, err_n, done_k);
    check("to_stb_cycles", stb_n, 15);
    check("to_done_cnt", done_n, 1);
    check("to_err_cnt", err_n, 1);
    check("to_done_at", done_k, 15);
    check("to_data", {16'd0, cpu_dat}, 32'hFFFF);

    // ack on the 15th stb cycle wins over the timeout
    run_xfer(1'b0, 16'h8004, 16'h0, 16'h0A0A, 15, stb_n, done_n, err_n, done_k);
    check("last_stb_cycles", stb_n, 15);
    check("last_done_at", done_k, 15);
    check("last_err", err_n, 0);
    check("last_data", {16'd0, cpu_dat}, 32'h0A0A);

    // three back-to-back transfers with request held high
    wb.ack_i = 1'b0; wb.dat_i = 16'h7777;
    req = 1'b1; we = 1'b0; adr = 16'h1000;
    cyc_pat = '0; done_pat = '0; adr1 = '0; adr2 = '0; extra_done = 0;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 6) begin
        cyc_pat[k]  = wb.cyc_o;
        done_pat[k] = done;
      end else if (done || err) begin
        extra_done++;
      end
      if (k == 1) adr1 = wb.adr_o;
      if (k == 2) adr2 = wb.adr_o;
      if (k == 0) adr = 16'h2000;
      if (k == 4) req = 1'b0;
      wb.ack_i = wb.stb_o;
    end
    wb.ack_i = 1'b0;
    check("b2b_cyc_pattern", {26'd0, cyc_pat}, 32'h15);
    check("b2b_done_pattern", {26'd0, done_pat}, 32'h2A);
    check("b2b_extra_done", extra_done, 0);
    check("b2b_adr_held", {16'd0, adr1}, 32'h1000);
    check("b2b_adr_next", {16'd0, adr2}, 32'h2000);

    // reset in the second BUS cycle
    req = 1'b1; we = 1'b0; adr = 16'h3000;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("mid_stb_up", {31'd0, wb.stb_o}, 32'h1);
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_ctl", {29'd0, wb.stb_o, wb.cyc_o, busy}, 32'h0);
    rst_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || err) rst_done++;
    end
    check("mid_rst_no_done", rst_done, 0);
    check("mid_rst_cpu_dat", {16'd0, cpu_dat}, 32'h0);
    nrst = 1'b1;
    run_xfer(1'b0, 16'h3002, 16'h0, 16'h5A5A, 2, stb_n, done_n, err_n, done_k);
    check("post_rst_stb", stb_n, 2);
    check("post_rst_done_at", done_k, 2);
    check("post_rst_err", err_n, 0);
    check("post_rst_data", {16'd0, cpu_dat}, 32'h5A5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
